// File: rtl/bubble_sort_ctrl.sv
// Control FSM for an in-place bubble sort driving an external compare/swap datapath.
// Optional macro BUBBLE_SORT_EARLY_EXIT_EN: stop after the first pass with no swap.
module bubble_sort_ctrl #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             gt,
   output logic [IDX_W-1:0] idx_a,
   output logic [IDX_W-1:0] idx_b,
   output logic             cmp_en,
   output logic             swap_en,
   output logic             clear_eoc,
   output logic             preset_eoc,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      CMP,
      SWAP,
      NEXT,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 2);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   state_t           state;
   state_t           state_d;
   logic [IDX_W-1:0] i;
   logic [IDX_W-1:0] i_d;
   logic [IDX_W-1:0] j;
   logic [IDX_W-1:0] j_d;
   logic             end_pass;
   logic             last_pass;
   logic             early_stop;

   // Pass i compares j = 0 .. N-2-i
   assign end_pass  = (j == (LAST - i));
   assign last_pass = (i == LAST);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   logic swapped;
   logic swapped_d;

   always_comb begin
      swapped_d = swapped;
      if (state == INIT || (state == NEXT && end_pass))
         swapped_d = 1'b0;
      else if (state == SWAP)
         swapped_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         swapped <= 1'b0;
      else
         swapped <= swapped_d;
   end

   assign early_stop = !swapped;
`else
   assign early_stop = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
      end else begin
         state <= state_d;
         i     <= i_d;
         j     <= j_d;
      end
   end

   always_comb begin
      state_d = state;
      i_d     = i;
      j_d     = j;
      unique case (state)
         IDLE: begin
            if (start)
               state_d = INIT;
         end
         INIT: begin
            i_d     = '0;
            j_d     = '0;
            state_d = CMP;
         end
         CMP: begin
            state_d = gt ? SWAP : NEXT;
         end
         SWAP: begin
            state_d = NEXT;
         end
         NEXT: begin
            if (!end_pass) begin
               j_d     = j + ONE;
               state_d = CMP;
            end else if (last_pass || early_stop) begin
               state_d = DONE;
            end else begin
               i_d     = i + ONE;
               j_d     = '0;
               state_d = CMP;
            end
         end
         DONE: begin
            i_d     = '0;
            j_d     = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // idx_b held at 0 outside CMP/SWAP so reset and idle outputs are all zero
   assign idx_a      = j;
   assign idx_b      = (state == CMP || state == SWAP) ? j + ONE : '0;
   assign cmp_en     = (state == CMP);
   assign swap_en    = (state == SWAP);
   assign clear_eoc  = (state == INIT);
   assign preset_eoc = (state == DONE);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl: an N=8 and an N=2 instance
// share clock and reset; the bench models the compare/swap datapath.
module tb_bubble_sort_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic       gt8;
   logic [2:0] a8;
   logic [2:0] b8;
   logic       cmp8, swp8, clr8, pre8, busy8;
   logic       start2;
   logic       gt2;
   logic [0:0] a2;
   logic [0:0] b2;
   logic       cmp2, swp2, clr2, pre2, busy2;

   int mem8[8];
   int mem2[2];

   int n_chk = 0;
   int n_fail = 0;

   int bcnt, swaps, cmps, clr_n, clr_at, pre_n, pre_at, maxa, maxb;
   bit cur_busy;

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
   localparam int EXP_SORTED_BUSY = 16;
   localparam int EXP_SORTED_CMP  = 7;
`else
   localparam int EXP_SORTED_BUSY = 58;
   localparam int EXP_SORTED_CMP  = 28;
`endif

   assign gt8 = mem8[a8] > mem8[b8];
   assign gt2 = mem2[a2] > mem2[b2];

   bubble_sort_ctrl #(.N(8), .IDX_W(3)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .start      (start8),
      .gt         (gt8),
      .idx_a      (a8),
      .idx_b      (b8),
      .cmp_en     (cmp8),
      .swap_en    (swp8),
      .clear_eoc  (clr8),
      .preset_eoc (pre8),
      .busy       (busy8)
   );

   bubble_sort_ctrl #(.N(2), .IDX_W(1)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .start      (start2),
      .gt         (gt2),
      .idx_a      (a2),
      .idx_b      (b2),
      .cmp_en     (cmp2),
      .swap_en    (swp2),
      .clear_eoc  (clr2),
      .preset_eoc (pre2),
      .busy       (busy2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clr_stats();
      bcnt = 0; swaps = 0; cmps = 0;
      clr_n = 0; clr_at = -1; pre_n = 0; pre_at = -1;
      maxa = 0; maxb = 0;
   endtask

   // One clock: sample at negedge, apply datapath swaps, collect stats
   task automatic tick(input bit sel2);
      int t, ia, ib;
      bit b, sw, cm, cl, pr;
      @(negedge clk);
      b  = sel2 ? busy2 : busy8;
      sw = sel2 ? swp2 : swp8;
      cm = sel2 ? cmp2 : cmp8;
      cl = sel2 ? clr2 : clr8;
      pr = sel2 ? pre2 : pre8;
      ia = sel2 ? int'(a2) : int'(a8);
      ib = sel2 ? int'(b2) : int'(b8);
      if (swp8) begin
         t = mem8[a8]; mem8[a8] = mem8[b8]; mem8[b8] = t;
      end
      if (swp2) begin
         t = mem2[a2]; mem2[a2] = mem2[b2]; mem2[b2] = t;
      end
      cur_busy = b;
      if (b) begin
         bcnt++;
         if (sw) swaps++;
         if (cm) begin
            cmps++;
            if (ia > maxa) maxa = ia;
            if (ib > maxb) maxb = ib;
         end
         if (cl) begin clr_n++; clr_at = bcnt; end
         if (pr) begin pre_n++; pre_at = bcnt; end
      end
   endtask

   task automatic run(input bit sel2, input bit hold, input int budget);
      bit seen, fin;
      clr_stats();
      seen = 0; fin = 0;
      if (sel2) start2 = 1'b1; else start8 = 1'b1;
      for (int c = 0; c < budget && !fin; c++) begin
         tick(sel2);
         if (!hold) begin start2 = 1'b0; start8 = 1'b0; end
         if (cur_busy) seen = 1;
         else if (seen) fin = 1;
      end
      if (!fin) check("run_timeout", 0, 1);
   endtask

   function automatic int outs8();
      return int'({a8, b8, cmp8, swp8, clr8, pre8, busy8});
   endfunction

   function automatic int outs2();
      return int'({a2, b2, cmp2, swp2, clr2, pre2, busy2});
   endfunction

   initial begin
      int mix[8];
      int snap[8];
      int bad, diff;
      bit hit;
      mix = '{3, 1, 2, 0, 7, 5, 6, 4};
      rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
      for (int k = 0; k < 8; k++) mem8[k] = k;
      mem2[0] = 0; mem2[1] = 0;
      #1;
      check("reset_outs8", outs8(), 0);
      check("reset_outs2", outs2(), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Pre-sorted data
      run(0, 0, 200);
      check("sorted_busy", bcnt, EXP_SORTED_BUSY);
      check("sorted_swaps", swaps, 0);
      check("sorted_cmps", cmps, EXP_SORTED_CMP);
      check("sorted_clr_n", clr_n, 1);
      check("sorted_clr_at", clr_at, 1);
      check("sorted_pre_n", pre_n, 1);
      check("sorted_pre_at", pre_at, EXP_SORTED_BUSY);
      check("idle_outs8", outs8(), 0);

      // Reverse data
      for (int k = 0; k < 8; k++) mem8[k] = 7 - k;
      run(0, 0, 200);
      check("rev_busy", bcnt, 86);
      check("rev_swaps", swaps, 28);
      check("rev_cmps", cmps, 28);
      check("rev_max_idx_a", maxa, 6);
      check("rev_max_idx_b", maxb, 7);
      check("rev_pre_at", pre_at, 86);
      for (int k = 0; k < 8; k++) check($sformatf("rev_mem%0d", k), mem8[k], k);

      // Mixed data, 10 inversions
      for (int k = 0; k < 8; k++) mem8[k] = mix[k];
      run(0, 0, 200);
      check("mix_swaps", swaps, 10);
`ifndef BUBBLE_SORT_EARLY_EXIT_EN
      check("mix_busy", bcnt, 68);
`endif
      for (int k = 0; k < 8; k++) check($sformatf("mix_mem%0d", k), mem8[k], k);

      // Reset at busy cycle 20 of a reverse sort
      for (int k = 0; k < 8; k++) mem8[k] = 7 - k;
      clr_stats();
      start8 = 1'b1;
      hit = 0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick(0);
         start8 = 1'b0;
         if (bcnt == 20) hit = 1;
      end
      check("rst_reach20", int'(hit), 1);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_outs8", outs8(), 0);
      snap = mem8;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         tick(0);
         if (pre8 || swp8 || busy8) bad++;
      end
      check("rst_quiet", bad, 0);
      check("rst_pre_n", pre_n, 0);
      diff = 0;
      for (int k = 0; k < 8; k++) if (mem8[k] != snap[k]) diff++;
      check("rst_mem_kept", diff, 0);
      rst = 1'b0;
      tick(0);
      check("rst_idle", int'(busy8), 0);
      run(0, 0, 200);
      check("resort_clr_at", clr_at, 1);
      check("resort_pre_n", pre_n, 1);
      for (int k = 0; k < 8; k++) check($sformatf("resort_mem%0d", k), mem8[k], k);

      // start held high through a whole sort
      for (int k = 0; k < 8; k++) mem8[k] = k;
      run(0, 1, 200);
      check("hold_busy", bcnt, EXP_SORTED_BUSY);
      check("hold_pre_n", pre_n, 1);
      check("hold_clr_n", clr_n, 1);
      tick(0);
      check("hold_restart_busy", int'(busy8), 1);
      check("hold_restart_clr", int'(clr8), 1);
      start8 = 1'b0;
      hit = 0;
      for (int c = 0; c < 200 && !hit; c++) begin
         tick(0);
         if (!busy8) hit = 1;
      end
      check("hold_drain", int'(hit), 1);

      // N=2
      mem2[0] = 5; mem2[1] = 3;
      run(1, 0, 50);
      check("n2_busy", bcnt, 5);
      check("n2_cmps", cmps, 1);
      check("n2_swaps", swaps, 1);
      check("n2_pre_at", pre_at, 5);
      check("n2_mem0", mem2[0], 3);
      check("n2_mem1", mem2[1], 5);
      check("n2_idle_outs", outs2(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bubble_sort_ctrl.md
BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

Interface
REQ-001 Parameter N, default 8: number of elements to sort; legal range 2..256.
REQ-002 Parameter IDX_W, default 3: index width; SHALL equal ceil(log2(N)).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  sort request; sampled only in IDLE.
REQ-006 gt  input  1  datapath compare result, mem[idx_a] > mem[idx_b]; valid in CMP.
REQ-007 idx_a  output  IDX_W  lower compare index j.
REQ-008 idx_b  output  IDX_W  upper compare index j+1.
REQ-009 cmp_en  output  1  high in CMP.
REQ-010 swap_en  output  1  high in SWAP; datapath exchanges mem[idx_a] and mem[idx_b].
REQ-011 clear_eoc  output  1  one-cycle pulse to the end-of-conversion register, high in INIT.
REQ-012 preset_eoc  output  1  one-cycle pulse to the end-of-conversion register, high in DONE.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, INIT, CMP, SWAP, NEXT, DONE; all outputs Moore-decoded from the state and counter registers.
REQ-015 IDLE: start=1 -> INIT, else stay; start in any other state SHALL be ignored.
REQ-016 INIT: pass counter i=0, index j=0, swapped flag=0; -> CMP.
REQ-017 CMP: idx_a=j, idx_b=j+1; gt=1 -> SWAP, gt=0 -> NEXT.
REQ-018 SWAP: swapped flag set to 1; -> NEXT.
REQ-019 NEXT, j < N-2-i: j increments; -> CMP.
REQ-020 NEXT, j = N-2-i and i = N-2: -> DONE.
REQ-021 NEXT, j = N-2-i and i < N-2: i increments, j=0, swapped flag=0; -> CMP.
REQ-022 DONE: -> IDLE unconditionally; start in the DONE cycle SHALL NOT be accepted.
REQ-023 Comparisons C SHALL be N(N-1)/2 without early exit; busy cycles SHALL be 2 + 2C + S, where S is the number of swaps.
REQ-024 Counters i and j SHALL never exceed N-2; idx_b SHALL never exceed N-1.
REQ-025 gt SHALL be ignored outside CMP.
REQ-026 With N=2: one comparison, then DONE.

Reset
REQ-027 rst=1 SHALL force IDLE, i=0, j=0, swapped flag=0 immediately, regardless of clk.
REQ-028 During reset, all outputs SHALL be 0.
REQ-029 Reset during a sort SHALL abort it with no further swap_en or preset_eoc; the datapath contents are then undefined-order but unmodified after reset.
REQ-030 After rst deasserts, the first start SHALL begin a fresh sort from INIT.

Configuration
REQ-031 Macro BUBBLE_SORT_EARLY_EXIT_EN, when defined: in NEXT at end of pass (j = N-2-i), swapped flag=0 -> DONE regardless of i.
REQ-032 Without BUBBLE_SORT_EARLY_EXIT_EN: the swapped flag SHALL NOT affect control flow, and all N-1 passes always run.

Verification
REQ-033 N=8, pre-sorted 0..7, macro off, start pulse -> busy high for exactly 58 cycles, swap_en never high, clear_eoc one pulse at the first busy cycle, preset_eoc one pulse at the last busy cycle.
REQ-034 N=8, reverse data 7..0, macro off -> 28 swap_en pulses, busy high for 86 cycles, final memory 0..7.
REQ-035 N=8, pre-sorted, macro on -> 7 comparisons, busy high for 16 cycles, preset_eoc asserted.
REQ-036 rst asserted mid-sort at busy cycle 20 -> outputs 0 in the same cycle, no preset_eoc; a subsequent start -> full sort completes correctly.
REQ-037 start held high through an entire sort -> a new sort begins only from IDLE (one idle cycle after DONE); no start accepted while busy.
REQ-038 N=2, data {5,3} -> one CMP, one SWAP, busy high for 5 cycles, result {3,5}.
